sine_freq_meter: RTL
====================

// Module: sine_freq_meter
// PURPOSE
//  Receive-side companion to the phase-accumulator sine generators. Takes a signed 16-bit
//  sample stream, detects rising zero crossings with hysteresis, and counts samples over
//  2^AVG_LOG2 periods. It then runs a sequential divide to recover the equivalent 32-bit
//  phase step. Used for loopback checks of the generator and for tone tracking.
// PARAMETERS
//  HYST      default 256  crossing hysteresis threshold, in sample LSBs (0 < HYST < 32768)
//  AVG_LOG2  default 2    number of periods averaged per estimate = 2^AVG_LOG2 (0..4)
//  CNT_W     default 24   width of the window sample counter; also sets the timeout
// PORTS
//  i_clk           in   1   clock
//  i_rst_n         in   1   synchronous reset, active low
//  i_sample        in   16  signed input sample
//  i_sample_valid  in   1   i_sample is valid this cycle; there is no backpressure
//  o_phase_step    out  32  latest estimate of floor(2^(32+AVG_LOG2)/S); held between updates
//  o_valid         out  1   one-cycle pulse when o_phase_step updates
//  o_lock          out  1   at least one estimate has been made since reset or timeout
//  o_busy          out  1   divider running
//  o_overrun       out  1   one-cycle pulse when a completed window is discarded
// BEHAVIOUR
//  - Reset: all outputs 0, FSM in IDLE, arm flag 0, counters 0. Reset wins over every other event.
//  - Only cycles with i_sample_valid=1 advance anything sample-related.
//  - Edge detector: arm<=1 when sample <= -HYST. Event is raised when arm=1 and sample >= +HYST;
//    the event clears arm. Excursions inside (-HYST,+HYST) never produce an event.
//  - FSM IDLE: wait for the first event, then clear count and per=0 and go to MEASURE.
//  - MEASURE: count increments on each valid sample; each event increments per.
//    * When per reaches 2^AVG_LOG2, snapshot S=count, including the closing sample.
//    * In the same cycle, restart count=0 and per=0. The closing edge opens the next window.
//    * The divider starts on this snapshot.
//  - DIVIDE runs concurrently with MEASURE; measurement never stops.
//    * Uses a restoring divider that produces 1 quotient bit per clock, for 32 clocks.
//    * Numerator is 2^(32+AVG_LOG2); denominator is S, CNT_W bits wide.
//    * o_busy=1 throughout. The result is registered: o_valid pulses and o_phase_step loads
//      on cycle T+33, where T is the cycle of the closing sample.
//    * Saturation: if S <= 2^AVG_LOG2 the divide is skipped. o_phase_step=32'hFFFF_FFFF and
//      o_valid pulses on T+1.
//  - A window that closes while o_busy=1 is dropped. o_overrun pulses and the running divide
//    is unaffected.
//  - o_lock: set with the first o_valid; cleared on timeout.
//  - Timeout: the count would wrap past 2^CNT_W-1 before the window completes.
//    * FSM goes to IDLE, o_lock<=0, arm<=0.
//    * An in-flight divide still completes and updates o_phase_step.
//  - o_phase_step is never cleared except by reset.
// CONFIGURATION
//  FREQ_METER_PERIOD_OUT_EN defined:
//    * Adds output o_period_sum [CNT_W-1:0], which loads S on the same cycle as o_valid.
//    * On saturated results it loads the S that saturated. It resets to 0.
//  Undefined: the port and its register do not exist; all other behaviour is identical.
// TESTING
//  1. Defaults; square-like sine with period 64 samples (+/-20000), valid every clock.
//     -> Valid outputs show o_phase_step=32'h0400_0000, then o_lock=1.
//  2. Period 100 samples, valid every 3rd clock.
//     -> o_phase_step=32'h028F_5C28 with o_overrun never asserted.
//  3. Sine +/-20000 with +/-(HYST-1) noise added at zero crossings.
//     -> Estimate still 32'h0400_0000 for period 64; no extra events.
//  4. After lock, hold i_sample=0 for 2^24 valid samples.
//     -> o_lock falls to 0; o_phase_step holds its last value.
//  5. Period 4, AVG_LOG2=0, valid every clock.
//     -> Windows close every 4 clocks; o_overrun pulses; results are 32'h4000_0000.
//  6. Assert i_rst_n=0 for 1 clock while o_busy=1.
//     -> Next cycle all outputs are 0; no o_valid follows; re-lock works as in test 1.

Source files
------------

// File: rtl/sine_freq_meter.sv
// sine_freq_meter: counts samples over 2^AVG_LOG2 rising zero crossings and divides to a phase step.
// Optional macro FREQ_METER_PERIOD_OUT_EN adds o_period_sum, the window length behind each result.
module sine_freq_meter #(
    parameter int HYST     = 256,
    parameter int AVG_LOG2 = 2,
    parameter int CNT_W    = 24
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic signed [15:0] i_sample,
    input  logic               i_sample_valid,
    output logic [31:0]        o_phase_step,
    output logic               o_valid,
    output logic               o_lock,
    output logic               o_busy,
    output logic               o_overrun
`ifdef FREQ_METER_PERIOD_OUT_EN
    ,
    output logic [CNT_W-1:0]   o_period_sum
`endif
);
    localparam int PER_W = AVG_LOG2 + 1;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'((1 << AVG_LOG2) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // Bits of 2^(32+AVG_LOG2) above the 32 quotient positions seed the remainder.
    localparam logic [CNT_W-1:0] NUM_HIGH = CNT_W'(1 << AVG_LOG2);
    localparam logic signed [16:0] HYST_POS = 17'(HYST);
    localparam logic signed [16:0] HYST_NEG = -17'(HYST);

    typedef enum logic {ST_IDLE, ST_MEASURE} state_t;

    state_t           state_reg;
    logic             arm_reg;
    logic [CNT_W-1:0] count_reg;
    logic [PER_W-1:0] per_reg;
    logic             busy_reg;
    logic [4:0]       div_cnt_reg;
    logic [CNT_W-1:0] div_den_reg;
    logic [CNT_W-1:0] div_rem_reg;
    logic [31:0]      div_quo_reg;

    logic signed [16:0] sample_ext;
    logic               hit_high;
    logic               hit_low;
    logic               sample_event;
    logic               timeout;
    logic               close_window;
    logic               saturate;
    logic               div_last;
    logic               result_load;
    logic [CNT_W-1:0]   s_close;
    logic [CNT_W:0]     rem_shift;
    logic [CNT_W:0]     rem_diff;
    logic               q_bit;
    logic [CNT_W-1:0]   rem_next;
    logic [31:0]        quo_next;

    always_comb begin
        sample_ext   = {i_sample[15], i_sample};
        hit_high     = sample_ext >= HYST_POS;
        hit_low      = sample_ext <= HYST_NEG;
        sample_event = i_sample_valid && arm_reg && hit_high;
        // Timeout wins over a closing edge so S always fits in CNT_W bits.
        timeout      = i_sample_valid && (state_reg == ST_MEASURE) && (count_reg == CNT_MAX);
        close_window = (state_reg == ST_MEASURE) && sample_event && !timeout
                       && (per_reg == PER_LAST);
        s_close      = count_reg + CNT_W'(1);

        rem_shift    = {div_rem_reg, 1'b0};
        rem_diff     = rem_shift - {1'b0, div_den_reg};
        q_bit        = rem_shift >= {1'b0, div_den_reg};
        rem_next     = q_bit ? rem_diff[CNT_W-1:0] : rem_shift[CNT_W-1:0];
        quo_next     = {div_quo_reg[30:0], q_bit};

        div_last     = busy_reg && (div_cnt_reg == 5'd31);
        saturate     = close_window && !busy_reg && (s_close <= NUM_HIGH);
        result_load  = div_last || saturate;
    end

    assign o_busy = busy_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg    <= ST_IDLE;
            arm_reg      <= 1'b0;
            count_reg    <= '0;
            per_reg      <= '0;
            busy_reg     <= 1'b0;
            div_cnt_reg  <= '0;
            div_den_reg  <= '0;
            div_rem_reg  <= '0;
            div_quo_reg  <= '0;
            o_phase_step <= '0;
            o_valid      <= 1'b0;
            o_lock       <= 1'b0;
            o_overrun    <= 1'b0;
`ifdef FREQ_METER_PERIOD_OUT_EN
            o_period_sum <= '0;
`endif
        end else begin
            o_valid   <= 1'b0;
            o_overrun <= busy_reg && close_window;

            if (i_sample_valid) begin
                if (sample_event) begin
                    arm_reg <= 1'b0;
                end else if (hit_low) begin
                    arm_reg <= 1'b1;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (sample_event) begin
                        count_reg <= '0;
                        per_reg   <= '0;
                        state_reg <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (i_sample_valid) begin
                        if (timeout) begin
                            state_reg <= ST_IDLE;
                            arm_reg   <= 1'b0;
                        end else if (close_window) begin
                            count_reg <= '0;
                            per_reg   <= '0;
                        end else begin
                            count_reg <= count_reg + CNT_W'(1);
                            if (sample_event) begin
                                per_reg <= per_reg + PER_W'(1);
                            end
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            // Divider keeps running across timeouts; a window closing while busy is dropped.
            if (busy_reg) begin
                div_rem_reg <= rem_next;
                div_quo_reg <= quo_next;
                div_cnt_reg <= div_cnt_reg + 5'd1;
                if (div_last) begin
                    busy_reg     <= 1'b0;
                    o_valid      <= 1'b1;
                    o_phase_step <= quo_next;
`ifdef FREQ_METER_PERIOD_OUT_EN
                    o_period_sum <= div_den_reg;
`endif
                end
            end else if (close_window) begin
                if (saturate) begin
                    o_valid      <= 1'b1;
                    o_phase_step <= 32'hFFFF_FFFF;
`ifdef FREQ_METER_PERIOD_OUT_EN
                    o_period_sum <= s_close;
`endif
                end else begin
                    busy_reg    <= 1'b1;
                    div_den_reg <= s_close;
                    div_rem_reg <= NUM_HIGH;
                    div_quo_reg <= '0;
                    div_cnt_reg <= '0;
                end
            end

            if (timeout) begin
                o_lock <= 1'b0;
            end else if (result_load) begin
                o_lock <= 1'b1;
            end
        end
    end

endmodule
